apexii_ddio_burst_ctrl: RTL and testbench

Burst sequencer that sits directly upstream of the APEX II DDIO bidirectional pad wrapper and drives it. It accepts read/write burst commands on a valid/ready interface. For writes, it splits each 2*WIDTH word into high/low DDIO halves and drives output-enable. For reads, it releases the pad, waits out bus turnaround, and reassembles the captured high/low halves into 2*WIDTH words tagged with rd_valid.

---
 rtl/apexii_ddio_burst_ctrl.sv | 91 +++++++++
 tb/tb_apexii_ddio_burst_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/apexii_ddio_burst_ctrl.sv
// apexii_ddio_burst_ctrl: burst sequencer driving the APEX II DDIO pad wrapper.
// It splits write words into DDIO halves and reassembles read halves into words.
module apexii_ddio_burst_ctrl #(
  parameter int WIDTH      = 8,
  parameter int BURST_LEN  = 4,
  parameter int TURNAROUND = 1,
  parameter int RD_LATENCY = 2
) (
  input  logic               clock,
  input  logic               sclr,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [2*WIDTH-1:0] wr_data,
  output logic               wr_ready,
  output logic [2*WIDTH-1:0] rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic [WIDTH-1:0]   ddio_datain_h,
  output logic [WIDTH-1:0]   ddio_datain_l,
  output logic               ddio_oe,
  output logic               ddio_outclkena,
  output logic               ddio_inclkena,
  input  logic [WIDTH-1:0]   ddio_dataout_h,
  input  logic [WIDTH-1:0]   ddio_dataout_l
);
  typedef enum logic [2:0] {IDLE, TURN, WRITE, READ, DRAIN} state_t;
  localparam int CMAX = BURST_LEN > TURNAROUND ? BURST_LEN : TURNAROUND;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [1:0] DIR_NONE = 2'd0, DIR_WR = 2'd1, DIR_RD = 2'd2;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic                    dir_q;
  logic [1:0]              last_q;
  logic [RD_LATENCY-1:0]   sr_q, sr_d;
  logic                    rd_valid_q, oe_q, inclk_q;
  logic [2*WIDTH-1:0]      rd_data_q, din_q;
  logic                    turn, burst_end, turn_end;
  assign cmd_ready      = state_q == IDLE;
  assign wr_ready       = state_q == WRITE;
  assign busy           = state_q != IDLE || |sr_q;
  assign rd_valid       = rd_valid_q;
  assign rd_data        = rd_data_q;
  assign ddio_datain_h  = din_q[2*WIDTH-1:WIDTH];
  assign ddio_datain_l  = din_q[WIDTH-1:0];
  assign ddio_oe        = oe_q;
  assign ddio_outclkena = oe_q;
  assign ddio_inclkena  = inclk_q;
  // Each read cycle injects a token that surfaces RD_LATENCY cycles later.
  assign sr_d      = RD_LATENCY'({sr_q, state_q == READ});
  assign turn      = TURNAROUND > 0 && last_q != DIR_NONE && ((last_q == DIR_WR) != cmd_write);
  assign burst_end = cnt_q == CW'(BURST_LEN - 1);
  assign turn_end  = cnt_q == CW'(TURNAROUND - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !cmd_valid ? IDLE : turn ? TURN : cmd_write ? WRITE : READ;
      TURN:    state_d = !turn_end ? TURN : dir_q ? WRITE : READ;
      WRITE:   state_d = burst_end ? IDLE : WRITE;
      READ:    state_d = burst_end ? DRAIN : READ;
      DRAIN:   state_d = sr_d == '0 ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      last_q     <= DIR_NONE;
      sr_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      din_q      <= '0;
      oe_q       <= 1'b0;
      inclk_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= (state_d != state_q || state_q == IDLE || state_q == DRAIN) ? '0 : cnt_q + CW'(1);
      sr_q       <= sr_d;
      rd_valid_q <= sr_q[RD_LATENCY-1];
      oe_q       <= state_q == WRITE;
      inclk_q    <= state_d == READ || state_d == DRAIN;
      if (state_q == IDLE && cmd_valid) dir_q <= cmd_write;
      if (sr_q[RD_LATENCY-1]) rd_data_q <= {ddio_dataout_h, ddio_dataout_l};
      if (state_q == WRITE) din_q <= wr_data;
      if (state_q == WRITE && state_d == IDLE) last_q <= DIR_WR;
      if (state_q == DRAIN && state_d == IDLE) last_q <= DIR_RD;
    end
  end
endmodule

// File: tb/tb_apexii_ddio_burst_ctrl.sv
// tb_apexii_ddio_burst_ctrl: directed plus random bench against a per-cycle schedule model.
// Each accepted command is expanded into the exact cycles where every output must toggle.
module tb_apexii_ddio_burst_ctrl;
  localparam int W = 8, BL = 4, TA = 1, RL = 2, N = 4096;
  logic clock, sclr, cmd_valid, cmd_ready, cmd_write, wr_ready, rd_valid, busy;
  logic [2*W-1:0] wr_data, rd_data;
  logic [W-1:0] ddio_datain_h, ddio_datain_l, ddio_dataout_h, ddio_dataout_l;
  logic ddio_oe, ddio_outclkena, ddio_inclkena;
  apexii_ddio_burst_ctrl #(.WIDTH(W), .BURST_LEN(BL), .TURNAROUND(TA), .RD_LATENCY(RL)) dut (
    .clock(clock), .sclr(sclr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .wr_data(wr_data), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .ddio_datain_h(ddio_datain_h),
    .ddio_datain_l(ddio_datain_l), .ddio_oe(ddio_oe), .ddio_outclkena(ddio_outclkena),
    .ddio_inclkena(ddio_inclkena), .ddio_dataout_h(ddio_dataout_h),
    .ddio_dataout_l(ddio_dataout_l)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  int checks = 0, failures = 0, cyc = 0, free = 0, m_last = 0, n_acc = 0;
  bit e_wrr[N], e_oe[N], e_incl[N], e_rdv[N], e_cap[N], e_dset[N], e_rset[N];
  logic [2*W-1:0] e_din[N], e_rd[N];
  logic [2*W-1:0] cur_din, cur_rd;
  logic [2*W-1:0] wtab[4] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic check_all();
    if (e_dset[cyc]) cur_din = e_din[cyc];
    if (e_rset[cyc]) cur_rd = e_rd[cyc];
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, cyc >= free});
    chk("busy", {31'd0, busy}, {31'd0, cyc < free});
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, e_wrr[cyc]});
    chk("ddio_oe", {31'd0, ddio_oe}, {31'd0, e_oe[cyc]});
    chk("outclkena", {31'd0, ddio_outclkena}, {31'd0, e_oe[cyc]});
    chk("inclkena", {31'd0, ddio_inclkena}, {31'd0, e_incl[cyc]});
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, e_rdv[cyc]});
    chk("datain", {16'd0, ddio_datain_h, ddio_datain_l}, {16'd0, cur_din});
    chk("rd_data", {16'd0, rd_data}, {16'd0, cur_rd});
  endtask
  // Drive one cycle of inputs, update the schedule model, then advance and check.
  task automatic drive(input logic cv, input logic cw, input logic [2*W-1:0] wd,
                       input logic [W-1:0] dh, input logic [W-1:0] dl, input logic rst);
    int s, e;
    bit turn;
    cmd_valid = cv; cmd_write = cw; wr_data = wd;
    ddio_dataout_h = dh; ddio_dataout_l = dl; sclr = rst;
    if (e_wrr[cyc]) begin e_din[cyc+1] = wd; e_dset[cyc+1] = 1; end
    if (e_cap[cyc]) begin e_rd[cyc+1] = {dh, dl}; e_rset[cyc+1] = 1; end
    if (cv && !rst && cyc >= free) begin
      n_acc++;
      turn = TA > 0 && m_last != 0 && ((m_last == 1) != cw);
      s = cyc + 1 + (turn ? TA : 0);
      if (cw) begin
        for (int k = 0; k < BL; k++) begin e_wrr[s+k] = 1; e_oe[s+k+1] = 1; end
        e = s + BL; m_last = 1;
      end else begin
        for (int k = 0; k < BL; k++) begin e_cap[s+k+RL] = 1; e_rdv[s+k+RL+1] = 1; end
        e = s + BL + RL; m_last = 2;
        for (int i = s; i < e; i++) e_incl[i] = 1;
      end
      free = e;
    end
    if (rst) begin
      for (int i = cyc + 1; i < N; i++) begin
        e_wrr[i] = 0; e_oe[i] = 0; e_incl[i] = 0; e_rdv[i] = 0;
        e_cap[i] = 0; e_dset[i] = 0; e_rset[i] = 0;
      end
      e_dset[cyc+1] = 1; e_din[cyc+1] = '0;
      e_rset[cyc+1] = 1; e_rd[cyc+1] = '0;
      free = cyc + 1; m_last = 0;
    end
    @(posedge clock);
    #1;
    cyc++;
    check_all();
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom), 1'b0);
  endtask
  task automatic cmd(input logic cw);
    while (cyc < free) idle();
    drive(1'b1, cw, 16'($urandom), 8'($urandom), 8'($urandom), 1'b0);
  endtask
  initial begin
    int target, j;
    repeat (3) drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    // Write burst with known data; first command after reset sees no turnaround.
    cmd(1'b1);
    for (int k = 0; k < BL; k++) drive(1'b0, 1'b0, wtab[k], 8'($urandom), 8'($urandom), 1'b0);
    chk("wr_last_beat", {16'd0, ddio_datain_h, ddio_datain_l}, 32'h0718);
    repeat (2) idle();
    chk("wr_hold", {16'd0, ddio_datain_h, ddio_datain_l}, 32'h0718);
    // Read after write: pad data ramps across the capture cycles.
    cmd(1'b0);
    for (int i = 1; i <= TA + 1 + BL + RL + 2; i++) begin
      j = i - (TA + 1 + RL);
      if (j >= 0 && j < BL)
        drive(1'b0, 1'b0, 16'($urandom), 8'(8'h10 + 2*j), 8'(8'h11 + 2*j), 1'b0);
      else idle();
    end
    chk("rd_last_beat", {16'd0, rd_data}, 32'h1617);
    // Two reads requested by holding cmd_valid high throughout.
    target = n_acc + 2;
    for (int k = 0; k < 60 && n_acc < target; k++)
      drive(1'b1, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    chk("two_reads_accepted", n_acc, target);
    repeat (12) idle();
    // Reset during the second write beat, then a read with no turnaround.
    cmd(1'b1);
    repeat (TA + 1) idle();
    drive(1'b0, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    chk("rst_wr_oe", {31'd0, ddio_oe}, 32'd0);
    cmd(1'b0);
    repeat (BL + RL + 2) idle();
    // Reset in the first drain cycle drops the two pending beats.
    cmd(1'b0);
    repeat (BL) idle();
    drive(1'b0, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    repeat (4) idle();
    chk("rst_drain_rd_data", {16'd0, rd_data}, 32'd0);
    // Random traffic with occasional resets.
    for (int k = 0; k < 1500; k++)
      drive(($urandom % 3) == 0, 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
            ($urandom % 60) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
